// File: rtl/alu_op_issuer_pkg.sv
// alu_op_issuer_pkg: opcodes, opcode type and FSM state encoding shared
// by the ALU request issuer and its request FIFO.
package alu_op_issuer_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_AND  = 3'b001;
  localparam op_t OP_OR   = 3'b010;
  localparam op_t OP_MUL  = 3'b011;
  localparam op_t OP_SUB  = 3'b100;
  localparam op_t OP_SLT  = 3'b101;
  localparam op_t OP_ILL6 = 3'b110;
  localparam op_t OP_ILL7 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Opcodes the ALU does not define.
  function automatic logic op_is_illegal(input op_t op);
    return (op == OP_ILL6) || (op == OP_ILL7);
  endfunction

endpackage

// File: rtl/alu_op_issuer_fifo.sv
// alu_req_fifo: small synchronous FIFO holding packed {op, A, B, tag}
// requests. Pointers carry one extra wrap bit to tell full from empty.
// Storage is not reset; only the pointers are.
module alu_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Advance read/write pointers; simultaneous push and pop both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the pushed entry into storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: buffers tagged ALU requests, drives the registered ALU's
// A/B/Sel inputs, captures its registered result and returns tagged
// responses.
// Optional feature macro: ALU_ISSUE_OPCHECK_EN -- when defined, opcodes
// 110/111 are never issued and are answered directly with RspErr=1.
//
// state | meaning
// IDLE  | waiting for a buffered request
// ISSUE | ALU inputs stable, ALU registers its result at the closing edge
// CAPT  | ALU result and zero flag copied into the response registers
// RESP  | response presented, held until RspReady
module alu_op_issuer #(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [31:0]      ReqA,
  input  logic [31:0]      ReqB,
  input  logic [TAG_W-1:0] ReqTag,
  output logic [31:0]      AluA,
  output logic [31:0]      AluB,
  output logic [2:0]       AluSel,
  input  logic [31:0]      AluR,
  input  logic             AluZ,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [31:0]      RspData,
  output logic             RspZero,
  output logic [TAG_W-1:0] RspTag,
  output logic             RspErr
);

  import alu_op_issuer_pkg::*;

  localparam int ENTRY_W = 3 + 32 + 32 + TAG_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  op_t                head_op;
  logic [31:0]        head_a;
  logic [31:0]        head_b;
  logic [TAG_W-1:0]   head_tag;
  state_t             state;

  // Ready is gated by reset so the requester never sees a spurious accept.
  assign ReqReady   = RST_N & ~fifo_full;
  assign fifo_push  = ReqValid & ReqReady;
  assign fifo_wdata = {ReqOp, ReqA, ReqB, ReqTag};
  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  // The FSM is the only consumer: it pops from IDLE, or straight out of
  // RESP on the response handshake to keep one op per three cycles.
  assign fifo_pop = ~fifo_empty &
                    ((state == ST_IDLE) | ((state == ST_RESP) & RspReady));

  alu_req_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ALU_ISSUE_OPCHECK_EN
  logic rsp_err;
  assign RspErr = rsp_err;
`else
  assign RspErr = 1'b0;
`endif

  // Issue sequencing FSM with registered ALU-side and response-side outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      AluA     <= '0;
      AluB     <= '0;
      AluSel   <= '0;
      RspValid <= 1'b0;
      RspData  <= '0;
      RspZero  <= 1'b0;
      RspTag   <= '0;
`ifdef ALU_ISSUE_OPCHECK_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_ISSUE: state <= ST_CAPT;
        ST_CAPT: begin
          RspData  <= AluR;
          RspZero  <= AluZ;
          RspValid <= 1'b1;
`ifdef ALU_ISSUE_OPCHECK_EN
          rsp_err  <= 1'b0;
`endif
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A pop overrides the state's own next-state choice.
      if (fifo_pop) begin
        RspTag <= head_tag;
`ifdef ALU_ISSUE_OPCHECK_EN
        if (op_is_illegal(head_op)) begin
          RspData  <= '0;
          RspZero  <= 1'b0;
          rsp_err  <= 1'b1;
          RspValid <= 1'b1;
          state    <= ST_RESP;
        end else
`endif
        begin
          AluA   <= head_a;
          AluB   <= head_b;
          AluSel <= head_op;
          state  <= ST_ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed and randomized checks of alu_op_issuer
// against a behavioural scoreboard, with a registered ALU stub.
module tb_alu_op_issuer;

  localparam int TAG_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             ReqValid = 1'b0;
  logic             ReqReady;
  logic [2:0]       ReqOp = '0;
  logic [31:0]      ReqA = '0;
  logic [31:0]      ReqB = '0;
  logic [TAG_W-1:0] ReqTag = '0;
  logic [31:0]      AluA;
  logic [31:0]      AluB;
  logic [2:0]       AluSel;
  logic [31:0]      AluR;
  logic             AluZ;
  logic             RspValid;
  logic             RspReady = 1'b0;
  logic [31:0]      RspData;
  logic             RspZero;
  logic [TAG_W-1:0] RspTag;
  logic             RspErr;

  typedef struct {
    logic [31:0]      data;
    logic             zero;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   rsp_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_op_issuer #(.TAG_W(TAG_W), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqA(ReqA), .ReqB(ReqB), .ReqTag(ReqTag),
    .AluA(AluA), .AluB(AluB), .AluSel(AluSel), .AluR(AluR), .AluZ(AluZ),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspZero(RspZero), .RspTag(RspTag), .RspErr(RspErr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ALU arithmetic as seen by the datapath.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return prod[31:0];
      3'd4:    return a - b;
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU stub.
  logic [31:0] alu_r = 32'd0;
  always @(posedge CLK) alu_r <= alu_fn(AluSel, AluA, AluB);
  assign AluR = alu_r;
  assign AluZ = (alu_r == 32'd0);

  function automatic exp_t ref_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag  = tag;
    e.data = alu_fn(op, a, b);
    e.zero = (e.data == 32'd0);
    e.err  = 1'b0;
`ifdef ALU_ISSUE_OPCHECK_EN
    if (op >= 3'd6) begin
      e.data = 32'd0;
      e.zero = 1'b0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  bit          hold_prev = 1'b0;
  logic [31:0] p_data;
  logic        p_zero;
  logic        p_err;
  logic [TAG_W-1:0] p_tag;
  exp_t        e_mon;

  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", RspValid, 1);
        chk("hold_data", RspData, p_data);
        chk("hold_zero", RspZero, p_zero);
        chk("hold_err", RspErr, p_err);
        chk("hold_tag", RspTag, p_tag);
      end
      if (RspValid && RspReady) begin
        rsp_cyc.push_back(cyc);
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          chk("rsp_data", RspData, e_mon.data);
          chk("rsp_zero", RspZero, e_mon.zero);
          chk("rsp_err", RspErr, e_mon.err);
          chk("rsp_tag", RspTag, e_mon.tag);
        end
      end
      if (ReqValid && ReqReady) sb.push_back(ref_rsp(ReqOp, ReqA, ReqB, ReqTag));
      hold_prev = RspValid && !RspReady;
      p_data = RspData;
      p_zero = RspZero;
      p_err  = RspErr;
      p_tag  = RspTag;
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input bit hold);
    bit ok;
    ok = 1'b0;
    ReqOp = op; ReqA = a; ReqB = b; ReqTag = tag; ReqValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (ReqReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accept", ok, 1);
    @(posedge CLK);
    #1;
    if (!hold) ReqValid = 1'b0;
  endtask

  // Edges after the call until RspValid is seen (0 on timeout).
  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (RspValid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !RspValid) break;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_no_valid", RspValid, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outs(input string pfx);
    chk({pfx, "_req_ready"}, ReqReady, 0);
    chk({pfx, "_alu_a"}, AluA, 0);
    chk({pfx, "_alu_b"}, AluB, 0);
    chk({pfx, "_alu_sel"}, AluSel, 0);
    chk({pfx, "_rsp_valid"}, RspValid, 0);
    chk({pfx, "_rsp_data"}, RspData, 0);
    chk({pfx, "_rsp_zero"}, RspZero, 0);
    chk({pfx, "_rsp_tag"}, RspTag, 0);
    chk({pfx, "_rsp_err"}, RspErr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  bit rnd_done = 1'b0;

  initial begin
    int k;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    RspReady = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outs("rst");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    #1;
    chk("ready_after_rst", ReqReady, 1);

    // Single add: pop at E1, response valid after E3.
    @(posedge CLK); #1;
    send(3'd0, 32'd5, 32'd7, 4'd3, 1'b0);
    @(posedge CLK); #1;
    chk("add_alu_a", AluA, 5);
    chk("add_alu_b", AluB, 7);
    chk("add_alu_sel", AluSel, 0);
    chk("add_not_yet_valid", RspValid, 0);
    wait_valid(k);
    chk("add_latency", k + 1, 3);
    chk("add_data", RspData, 12);
    chk("add_zero", RspZero, 0);
    chk("add_tag", RspTag, 3);
    chk("add_err", RspErr, 0);
    drain();

    // Sub to zero, then truncated multiply.
    send(3'd4, 32'd9, 32'd9, 4'd5, 1'b0);
    wait_valid(k);
    chk("sub_data", RspData, 0);
    chk("sub_zero", RspZero, 1);
    chk("sub_tag", RspTag, 5);
    drain();
    send(3'd3, 32'h0001_0000, 32'h0001_0000, 4'd6, 1'b0);
    wait_valid(k);
    chk("mul_data", RspData, 0);
    chk("mul_zero", RspZero, 1);
    drain();

    // Back-to-back burst: FIFO fills, responses three cycles apart.
    rsp_cyc.delete();
    send(3'd0, 32'd1, 32'd2, 4'd1, 1'b1);
    send(3'd4, 32'd10, 32'd3, 4'd2, 1'b1);
    send(3'd2, 32'hF0, 32'h0F, 4'd3, 1'b0);
    @(negedge CLK);
    chk("burst_full_ready", ReqReady, 0);
    drain();
    chk("burst_rsp_count", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("burst_gap01", rsp_cyc[1] - rsp_cyc[0], 3);
      chk("burst_gap12", rsp_cyc[2] - rsp_cyc[1], 3);
    end

    // Consumer stall: response held, FIFO fills behind it.
    RspReady = 1'b0;
    send(3'd0, 32'd100, 32'd200, 4'd6, 1'b0);
    wait_valid(k);
    chk("stall_latency", k, 3);
    send(3'd1, 32'hFF00, 32'h0FF0, 4'd7, 1'b0);
    send(3'd5, 32'd3, 32'd4, 4'd8, 1'b0);
    repeat (10) @(negedge CLK);
    chk("stall_valid", RspValid, 1);
    chk("stall_data", RspData, 300);
    chk("stall_tag", RspTag, 6);
    chk("stall_fifo_full", ReqReady, 0);
    @(posedge CLK); #1;
    RspReady = 1'b1;
    drain();

    // Opcode 111.
    send(3'd7, 32'h1234, 32'h5678, 4'd9, 1'b0);
    wait_valid(k);
`ifdef ALU_ISSUE_OPCHECK_EN
    chk("ill_latency", k, 1);
    chk("ill_err", RspErr, 1);
    chk("ill_zero", RspZero, 0);
`else
    chk("ill_latency", k, 3);
    chk("ill_err", RspErr, 0);
    chk("ill_zero", RspZero, 1);
`endif
    chk("ill_data", RspData, 0);
    chk("ill_tag", RspTag, 9);
    drain();

    // Reset during CAPT discards the in-flight op.
    send(3'd0, 32'd1, 32'd1, 4'd2, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check_reset_outs("rst_capt");
    sb.delete();
    repeat (3) begin
      @(negedge CLK);
      chk("rst_no_rsp", RspValid, 0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    send(3'd4, 32'd50, 32'd8, 4'd4, 1'b0);
    wait_valid(k);
    chk("post_rst_latency", k, 3);
    chk("post_rst_data", RspData, 42);
    chk("post_rst_tag", RspTag, 4);
    drain();

    // Randomized traffic with random back-pressure.
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          r_op = 3'($urandom_range(0, 7));
          r_a  = $urandom;
          r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
          if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 20));
          send(r_op, r_a, r_b, 4'($urandom_range(0, 15)), 1'b0);
          repeat ($urandom_range(0, 2)) @(posedge CLK);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK);
          #1;
          RspReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    RspReady = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
